adc_spi_master: RTL and testbench

ADC_SPI_MASTER -- requirements
Module: adc_spi_master

---
 rtl/adc_spi_master_pkg.sv | 15 +
 rtl/adc_spi_master_if.sv | 23 ++
 rtl/adc_fmt.sv | 17 +
 rtl/adc_spi_master.sv | 118 +++++++++++
 tb/tb_adc_spi_master.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_master_pkg.sv
// adc_spi_master_pkg: shared frame/resolution constants and FSM encoding
package adc_spi_master_pkg;
    localparam int ANCHO          = 16;
    localparam int RESOLUCION     = 12;
    localparam int FRAME_BITS_DEF = ANCHO;
    localparam int RES_BITS_DEF   = RESOLUCION;
    localparam int PAD_BITS_DEF   = 2;
    localparam int OUT_W_DEF      = 16;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_QUIET = 2'd3
    } state_e;
endpackage

// File: rtl/adc_spi_master_if.sv
// adc_spi_master_if: ADC pins plus the sample handshake towards the consumer
interface adc_spi_master_if #(
    parameter int OUT_W = adc_spi_master_pkg::OUT_W_DEF
);
    logic             start;
    logic             cont;
    logic             sdata;
    logic             cs_n;
    logic             sclk;
    logic             busy;
    logic [OUT_W-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             overrun;
    modport master (
        input  start, cont, sdata, data_ready,
        output cs_n, sclk, busy, data_out, data_valid, overrun
    );
    modport slave (
        output start, cont, sdata, data_ready,
        input  cs_n, sclk, busy, data_out, data_valid, overrun
    );
endinterface

// File: rtl/adc_fmt.sv
// adc_fmt: raw ADC code to sign-extended, zero-padded output word
module adc_fmt
    import adc_spi_master_pkg::*;
#(
    parameter int RES_BITS   = RES_BITS_DEF,
    parameter int PAD_BITS   = PAD_BITS_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic [RES_BITS-1:0] raw,
    output logic [OUT_W-1:0]    data
);
    logic signed [RES_BITS-1:0] code;
    assign code = {raw[RES_BITS-1] ^ OFFSET_BIN, raw[RES_BITS-2:0]};
    // widening a signed value sign-extends; the shift pushes the surplus sign bits out
    assign data = OUT_W'(code) << PAD_BITS;
endmodule

// File: rtl/adc_spi_master.sv
// adc_spi_master: frames the ADC over SPI and presents formatted samples with a valid/ready handshake
module adc_spi_master
    import adc_spi_master_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int RES_BITS   = RES_BITS_DEF,
    parameter int PAD_BITS   = PAD_BITS_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int CLK_DIV    = 4,
    parameter int T_QUIET    = 4,
    parameter bit OFFSET_BIN = 1'b1
) (
    input logic              clk,
    input logic              reset,
    adc_spi_master_if.master bus
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TMR_W = $clog2((CLK_DIV > T_QUIET ? CLK_DIV : T_QUIET) + 1);

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0]    bit_q, bit_d;
    logic [RES_BITS-1:0] shift_q, shift_d;
    logic [OUT_W-1:0]    dout_q, dout_d, fmt_out;
    logic                sclk_q, sclk_d, valid_q, valid_d, ovr_q, ovr_d;
    logic                div_end, quiet_end, last_bit, done;

    assign div_end   = tmr_q == TMR_W'(CLK_DIV - 1);
    assign quiet_end = tmr_q == TMR_W'(T_QUIET - 1);
    assign last_bit  = bit_q == CNT_W'(FRAME_BITS - 1);
    // frame ends after the final high half-period of sclk
    assign done      = state_q == ST_SHIFT && div_end && sclk_q && last_bit;

    adc_fmt #(
        .RES_BITS  (RES_BITS),
        .PAD_BITS  (PAD_BITS),
        .OUT_W     (OUT_W),
        .OFFSET_BIN(OFFSET_BIN)
    ) u_fmt (
        .raw (shift_q),
        .data(fmt_out)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        case (state_q)
            ST_IDLE: begin
                tmr_d  = '0;
                sclk_d = 1'b1;
                if (bus.start || bus.cont) begin
                    state_d = ST_SETUP;
                    bit_d   = '0;
                    shift_d = '0;
                end
            end
            ST_SETUP: if (div_end) begin
                state_d = ST_SHIFT;
                tmr_d   = '0;
                sclk_d  = 1'b0;
            end
            ST_SHIFT: if (div_end) begin
                tmr_d = '0;
                if (!sclk_q) begin
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[RES_BITS-2:0], bus.sdata};
                end else if (last_bit) begin
                    state_d = ST_QUIET;
                end else begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + 1'b1;
                end
            end
            ST_QUIET: if (quiet_end) begin
                state_d = bus.cont ? ST_SETUP : ST_IDLE;
                tmr_d   = '0;
                bit_d   = '0;
                shift_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        dout_d  = done ? fmt_out : dout_q;
        valid_d = done | (valid_q & ~bus.data_ready);
        ovr_d   = done & valid_q & ~bus.data_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b1;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.cs_n       = !(state_q == ST_SETUP || state_q == ST_SHIFT);
    assign bus.sclk       = sclk_q;
    assign bus.busy       = state_q != ST_IDLE;
    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_adc_spi_master.sv
// tb_adc_spi_master: directed checks of framing, formatting, handshake, overrun and reset abort
module tb_adc_spi_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [15:0] frame = '0;
    int          bidx = 0;

    adc_spi_master_if #(.OUT_W(16)) bus ();
    adc_spi_master_if #(.OUT_W(16)) bus2 ();

    adc_spi_master dut (.clk(clk), .reset(reset), .bus(bus));
    adc_spi_master #(.OFFSET_BIN(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus2.start      = bus.start;
    assign bus2.cont       = bus.cont;
    assign bus2.sdata      = bus.sdata;
    assign bus2.data_ready = bus.data_ready;

    always #5 clk = ~clk;

    // ADC model: next frame bit presented on every falling sclk, MSB first
    always @(negedge bus.sclk or posedge bus.cs_n) begin
        if (bus.cs_n) bidx = 0;
        else begin
            bus.sdata = (bidx < 16) ? frame[15 - bidx] : 1'b0;
            bidx = bidx + 1;
        end
    end

    task automatic do_start;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_high(output int n);
        n = 0;
        while (bus.cs_n === 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.cont = 1'b0;
        bus.data_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b exp=1", bus.cs_n); end
        total++; if (bus.sclk !== 1'b1) begin bad++; $display("FAIL reset_sclk got=%b exp=1", bus.sclk); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.data_valid); end
        total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", bus.data_out); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int n;
        frame = 16'h0FFF;
        bus.data_ready = 1'b0;
        do_start();
        total++; if (bus.cs_n !== 1'b0) begin bad++; $display("FAIL single_cs_fall got=%b exp=0", bus.cs_n); end
        wait_high(n);
        total++; if (n != 132) begin bad++; $display("FAIL single_cs_low got=%0d exp=132", n); end
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.data_valid); end
        total++; if (bus.data_out !== 16'h1FFC) begin bad++; $display("FAIL single_data got=%h exp=1ffc", bus.data_out); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_quiet got=%b exp=1", bus.busy); end
        bus.data_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL single_consume got=%b exp=0", bus.data_valid); end
        repeat (5) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_codes;
        logic [15:0] fr [4]  = '{16'h0000, 16'h0800, 16'hA123, 16'h0FFF};
        logic [15:0] ob [4]  = '{16'hE000, 16'h0000, 16'hE48C, 16'h1FFC};
        logic [15:0] tc [4]  = '{16'h0000, 16'hE000, 16'h048C, 16'hFFFC};
        int n;
        bus.data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame = fr[i];
            do_start();
            wait_high(n);
            total++; if (bus.data_out !== ob[i]) begin bad++; $display("FAIL code_offset frame=%h got=%h exp=%h", fr[i], bus.data_out, ob[i]); end
            total++; if (bus2.data_out !== tc[i]) begin bad++; $display("FAIL code_twos frame=%h got=%h exp=%h", fr[i], bus2.data_out, tc[i]); end
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_cont_overrun;
        int n;
        int hc;
        int ov;
        bus.data_ready = 1'b0;
        frame = 16'h0123;
        bus.cont = 1'b1;
        @(negedge clk);
        total++; if (bus.cs_n !== 1'b0) begin bad++; $display("FAIL cont_cs_fall got=%b exp=0", bus.cs_n); end
        wait_high(n);
        total++; if (bus.data_out !== 16'hE48C) begin bad++; $display("FAIL cont_first_data got=%h exp=e48c", bus.data_out); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL cont_first_overrun got=%b exp=0", bus.overrun); end
        frame = 16'h0456;
        hc = 0;
        ov = 0;
        while (bus.cs_n === 1'b1 && hc < 50) begin
            ov += int'(bus.overrun);
            hc++;
            @(negedge clk);
        end
        total++; if (hc != 4) begin bad++; $display("FAIL cont_gap got=%0d exp=4", hc); end
        total++; if (ov != 0) begin bad++; $display("FAIL cont_gap_overrun got=%0d exp=0", ov); end
        repeat (20) @(negedge clk);
        bus.cont = 1'b0;
        wait_high(n);
        total++; if (n + 20 != 132) begin bad++; $display("FAIL cont_second_low got=%0d exp=132", n + 20); end
        total++; if (bus.data_out !== 16'hF158) begin bad++; $display("FAIL cont_overwrite got=%h exp=f158", bus.data_out); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL cont_overrun got=%b exp=1", bus.overrun); end
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL cont_valid got=%b exp=1", bus.data_valid); end
        @(negedge clk);
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL cont_overrun_pulse got=%b exp=0", bus.overrun); end
        repeat (10) @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin bad++; $display("FAIL cont_stop got busy=%b cs_n=%b exp busy=0 cs_n=1", bus.busy, bus.cs_n); end
    endtask

    task automatic test_reset_mid;
        int lc;
        int vc;
        frame = 16'h0FFF;
        do_start();
        repeat (60) @(negedge clk);
        total++; if (bus.cs_n !== 1'b0 || bus.sclk !== 1'b0) begin bad++; $display("FAIL mid_pre got cs_n=%b sclk=%b exp 0 0", bus.cs_n, bus.sclk); end
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", bus.data_valid); end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL mid_cs_n got=%b exp=1", bus.cs_n); end
        total++; if (bus.sclk !== 1'b1) begin bad++; $display("FAIL mid_sclk got=%b exp=1", bus.sclk); end
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", bus.data_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        reset = 1'b0;
        lc = 0;
        vc = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.cs_n !== 1'b1) lc++;
            if (bus.data_valid !== 1'b0) vc++;
        end
        total++; if (lc != 0) begin bad++; $display("FAIL mid_no_restart got=%0d exp=0", lc); end
        total++; if (vc != 0) begin bad++; $display("FAIL mid_no_sample got=%0d exp=0", vc); end
    endtask

    task automatic test_ignore_start;
        int n;
        int lc;
        frame = 16'h0FFF;
        bus.data_ready = 1'b0;
        do_start();
        repeat (40) @(negedge clk);
        do_start();
        bus.data_ready = 1'b1;
        wait_high(n);
        total++; if (n + 41 != 132) begin bad++; $display("FAIL ign_cs_low got=%0d exp=132", n + 41); end
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL ign_valid got=%b exp=1", bus.data_valid); end
        total++; if (bus.data_out !== 16'h1FFC) begin bad++; $display("FAIL ign_data got=%h exp=1ffc", bus.data_out); end
        @(negedge clk);
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL ign_valid_one_cycle got=%b exp=0", bus.data_valid); end
        lc = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.cs_n !== 1'b1) lc++;
        end
        total++; if (lc != 0) begin bad++; $display("FAIL ign_one_frame got=%0d exp=0", lc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_codes();
        test_cont_overrun();
        test_reset_mid();
        test_ignore_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
